// File: rtl/write_burst_submodule.sv
// Burst write engine: fetches one data word per beat from the supermodule, then issues
// independent AW/W handshakes and waits for the B response. Repeats until len beats are done or an error aborts the burst.
module write_burst_submodule #(
   parameter int ADDR_WDTH    = 4,
   parameter int DATA_WDTH    = 32,
   parameter int RESP_WDTH    = 1,
   parameter int LEN_WDTH     = 4,
   parameter int ADDR_STEP    = 1,
   parameter int ABORT_ON_ERR = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 aw_valid,
   input  logic                 aw_ready,
   output logic [ADDR_WDTH-1:0] aw_address,
   output logic                 w_valid,
   input  logic                 w_ready,
   output logic [DATA_WDTH-1:0] w_data,
   input  logic                 b_valid,
   output logic                 b_ready,
   input  logic [RESP_WDTH-1:0] b_resp,
   input  logic                 start,
   input  logic [ADDR_WDTH-1:0] addr,
   input  logic [LEN_WDTH-1:0]  len,
   input  logic                 data_valid,
   output logic                 data_ready,
   input  logic [DATA_WDTH-1:0] data,
   output logic                 busy,
   output logic                 done,
   output logic [RESP_WDTH-1:0] resp,
   output logic                 err,
   output logic [LEN_WDTH-1:0]  beats_written
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      SEND   = 3'd2,
      WAIT_B = 3'd3,
      FINISH = 3'd4
   } state_t;

   localparam logic [ADDR_WDTH-1:0] ADDR_INC = ADDR_WDTH'(ADDR_STEP);

   state_t                state_q, state_d;
   logic [ADDR_WDTH-1:0]  aw_address_q, aw_address_d;
   logic [DATA_WDTH-1:0]  w_data_q, w_data_d;
   logic [LEN_WDTH-1:0]   remaining_q, remaining_d;
   logic [LEN_WDTH-1:0]   beats_q, beats_d;
   logic [RESP_WDTH-1:0]  resp_q, resp_d;
   logic                  err_q, err_d;
   logic                  aw_done_q, aw_done_d;
   logic                  w_done_q, w_done_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         aw_address_q <= '0;
         w_data_q     <= '0;
         remaining_q  <= '0;
         beats_q      <= '0;
         resp_q       <= '0;
         err_q        <= 1'b0;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         aw_address_q <= aw_address_d;
         w_data_q     <= w_data_d;
         remaining_q  <= remaining_d;
         beats_q      <= beats_d;
         resp_q       <= resp_d;
         err_q        <= err_d;
         aw_done_q    <= aw_done_d;
         w_done_q     <= w_done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      aw_address_d = aw_address_q;
      w_data_d     = w_data_q;
      remaining_d  = remaining_q;
      beats_d      = beats_q;
      resp_d       = resp_q;
      err_d        = err_q;
      aw_done_d    = aw_done_q;
      w_done_d     = w_done_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               beats_d = '0;
               err_d   = 1'b0;
               resp_d  = '0;
               if (len != '0) begin
                  aw_address_d = addr;
                  remaining_d  = len;
                  state_d      = FETCH;
               end else begin
                  state_d = FINISH;
               end
            end
         end
         FETCH: begin
            if (data_valid) begin
               w_data_d  = data;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = SEND;
            end
         end
         SEND: begin
            // The two channels complete independently; leave once both flags are set.
            if (aw_valid && aw_ready) aw_done_d = 1'b1;
            if (w_valid && w_ready)   w_done_d  = 1'b1;
            if (aw_done_d && w_done_d) state_d = WAIT_B;
         end
         WAIT_B: begin
            if (b_valid) begin
               beats_d     = beats_q + LEN_WDTH'(1);
               remaining_d = remaining_q - LEN_WDTH'(1);
               if ((b_resp != '0) && !err_q) begin
                  resp_d = b_resp;
                  err_d  = 1'b1;
               end
               if (((b_resp != '0) && (ABORT_ON_ERR != 0)) || (remaining_q == LEN_WDTH'(1))) begin
                  state_d = FINISH;
               end else begin
                  aw_address_d = aw_address_q + ADDR_INC;
                  state_d      = FETCH;
               end
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign aw_valid      = (state_q == SEND) && !aw_done_q;
   assign w_valid       = (state_q == SEND) && !w_done_q;
   assign b_ready       = (state_q == WAIT_B);
   assign data_ready    = (state_q == FETCH);
   assign busy          = (state_q != IDLE);
   assign done          = (state_q == FINISH);
   assign aw_address    = aw_address_q;
   assign w_data        = w_data_q;
   assign resp          = resp_q;
   assign err           = err_q;
   assign beats_written = beats_q;

endmodule

// File: tb/tb_write_burst_submodule.sv
// Randomized bench for write_burst_submodule: two instances (abort on / off) share stimulus,
// and each burst is checked against a beat-list model of the expected writes.
module tb_write_burst_submodule;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_a, start_b;
   logic [3:0]  addr, len;
   logic        data_valid;
   logic [31:0] data;
   logic        aw_ready, w_ready, b_valid;
   logic [0:0]  b_resp;

   logic        aw_valid_a, w_valid_a, b_ready_a, data_ready_a, busy_a, done_a, err_a;
   logic [3:0]  aw_address_a, beats_a;
   logic [31:0] w_data_a;
   logic [0:0]  resp_a;
   logic        aw_valid_b, w_valid_b, b_ready_b, data_ready_b, busy_b, done_b, err_b;
   logic [3:0]  aw_address_b, beats_b;
   logic [31:0] w_data_b;
   logic [0:0]  resp_b;

   logic        aw_valid, w_valid, b_ready, data_ready, busy, done, err;
   logic [3:0]  aw_address, beats;
   logic [31:0] w_data;
   logic [0:0]  resp;
   bit          use_b;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   write_burst_submodule #(.ADDR_WDTH(4), .DATA_WDTH(32), .RESP_WDTH(1), .LEN_WDTH(4),
                           .ADDR_STEP(1), .ABORT_ON_ERR(1)) dut_a (
      .clk(clk), .rst(rst),
      .aw_valid(aw_valid_a), .aw_ready(aw_ready), .aw_address(aw_address_a),
      .w_valid(w_valid_a), .w_ready(w_ready), .w_data(w_data_a),
      .b_valid(b_valid), .b_ready(b_ready_a), .b_resp(b_resp),
      .start(start_a), .addr(addr), .len(len),
      .data_valid(data_valid), .data_ready(data_ready_a), .data(data),
      .busy(busy_a), .done(done_a), .resp(resp_a), .err(err_a), .beats_written(beats_a));

   write_burst_submodule #(.ADDR_WDTH(4), .DATA_WDTH(32), .RESP_WDTH(1), .LEN_WDTH(4),
                           .ADDR_STEP(1), .ABORT_ON_ERR(0)) dut_b (
      .clk(clk), .rst(rst),
      .aw_valid(aw_valid_b), .aw_ready(aw_ready), .aw_address(aw_address_b),
      .w_valid(w_valid_b), .w_ready(w_ready), .w_data(w_data_b),
      .b_valid(b_valid), .b_ready(b_ready_b), .b_resp(b_resp),
      .start(start_b), .addr(addr), .len(len),
      .data_valid(data_valid), .data_ready(data_ready_b), .data(data),
      .busy(busy_b), .done(done_b), .resp(resp_b), .err(err_b), .beats_written(beats_b));

   always_comb begin
      aw_valid   = use_b ? aw_valid_b   : aw_valid_a;
      w_valid    = use_b ? w_valid_b    : w_valid_a;
      b_ready    = use_b ? b_ready_b    : b_ready_a;
      data_ready = use_b ? data_ready_b : data_ready_a;
      busy       = use_b ? busy_b       : busy_a;
      done       = use_b ? done_b       : done_a;
      err        = use_b ? err_b        : err_a;
      aw_address = use_b ? aw_address_b : aw_address_a;
      beats      = use_b ? beats_b      : beats_a;
      w_data     = use_b ? w_data_b     : w_data_a;
      resp       = use_b ? resp_b       : resp_a;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctl"}, {busy, done, aw_valid, w_valid, b_ready, data_ready, err}, 0);
      check({tag, "_addr"}, aw_address, 0);
      check({tag, "_wdata"}, w_data, 0);
      check({tag, "_beats"}, beats, 0);
      check({tag, "_resp"}, resp, 0);
   endtask

   // mode 0: zero-wait memory and supply; 1: random readies/valids; 2: aw_ready held off for 4 valid cycles
   task automatic run_burst(input bit sel, input logic [3:0] a, input logic [3:0] n,
                            input logic [15:0] errmask, input int mode);
      logic [3:0]  aw_log[$];
      logic [31:0] w_log[$];
      logic [31:0] sup[$];
      logic [31:0] next_data;
      logic [3:0]  prev_addr;
      logic [31:0] prev_wdata;
      bit          aw_pend, w_pend, exp_err, abort;
      logic [0:0]  exp_resp;
      int exp_n, cyc, post, done_cnt, done_cyc, awv_cnt, vcnt, bcnt, aw_hs_cyc, w_hs_cyc;

      // Reference: the beat list is len beats, truncated after the first error when aborting.
      abort    = !sel;
      exp_n    = 0;
      exp_err  = 1'b0;
      exp_resp = '0;
      for (int i = 0; i < int'(n); i++) begin
         exp_n++;
         if (errmask[i]) begin
            if (!exp_err) begin
               exp_err  = 1'b1;
               exp_resp = 1'b1;
            end
            if (abort) break;
         end
      end

      use_b = sel;
      next_data = $urandom;
      aw_pend = 1'b0; w_pend = 1'b0;
      cyc = 0; post = 0; done_cnt = 0; done_cyc = -1; awv_cnt = 0; vcnt = 0; bcnt = 0;
      aw_hs_cyc = -1; w_hs_cyc = -1;
      prev_addr = '0; prev_wdata = '0;

      @(negedge clk);
      addr = a;
      len  = n;
      if (sel) start_b = 1'b1; else start_a = 1'b1;

      while (1) begin
         @(negedge clk);
         cyc++;
         start_a = 1'b0;
         start_b = 1'b0;
         case (mode)
            0: begin
               aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b1; data_valid = 1'b1;
            end
            1: begin
               aw_ready   = ($urandom_range(0, 3) != 0);
               w_ready    = ($urandom_range(0, 3) != 0);
               b_valid    = ($urandom_range(0, 2) != 0);
               data_valid = ($urandom_range(0, 2) != 0);
            end
            default: begin
               w_ready = 1'b1; b_valid = 1'b1; data_valid = 1'b1;
               aw_ready = (awv_cnt >= 4);
            end
         endcase
         data   = next_data;
         b_resp = errmask[bcnt];
         #1;
         if (aw_valid) awv_cnt++;
         if (aw_valid || w_valid) vcnt++;
         if (aw_valid && aw_pend) check("aw_stable", aw_address, prev_addr);
         if (w_valid && w_pend) check("w_stable", w_data, prev_wdata);
         aw_pend    = aw_valid && !aw_ready;
         w_pend     = w_valid && !w_ready;
         prev_addr  = aw_address;
         prev_wdata = w_data;
         if (aw_valid && aw_ready) begin
            aw_log.push_back(aw_address);
            aw_hs_cyc = cyc;
         end
         if (w_valid && w_ready) begin
            w_log.push_back(w_data);
            w_hs_cyc = cyc;
         end
         if (data_ready && data_valid) begin
            sup.push_back(data);
            next_data = $urandom;
         end
         if (b_ready && b_valid) bcnt++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (done_cnt > 0) post++;
         if (post >= 3) break;
         if (cyc > 600) begin
            check("timeout", 0, 1);
            break;
         end
      end

      check("aw_count", aw_log.size(), exp_n);
      check("w_count", w_log.size(), exp_n);
      check("fetch_count", sup.size(), exp_n);
      for (int i = 0; i < exp_n; i++) begin
         if (i < aw_log.size()) check("aw_addr", aw_log[i], (int'(a) + i) % 16);
         if (i < w_log.size() && i < sup.size()) check("w_data", w_log[i], sup[i]);
      end
      check("done_once", done_cnt, 1);
      check("beats_written", beats, exp_n);
      check("err", err, exp_err);
      check("resp", resp, exp_resp);
      check("idle_after", busy, 0);
      if (mode == 0) check("latency", done_cyc, (exp_n > 0) ? 3 * exp_n + 1 : 1);
      if (exp_n == 0) check("no_valid", vcnt, 0);
      if (mode == 2) check("w_before_aw", (w_hs_cyc < aw_hs_cyc), 1);
   endtask

   task automatic reset_mid_wait_b();
      int cyc, dc;
      use_b = 1'b0;
      @(negedge clk);
      addr = 4'h7; len = 4'h3;
      start_a = 1'b1;
      aw_ready = 1'b1; w_ready = 1'b1; data_valid = 1'b1; b_valid = 1'b0;
      cyc = 0;
      while (1) begin
         @(negedge clk);
         start_a = 1'b0;
         cyc++;
         if (b_ready) break;
         if (cyc > 50) begin
            check("wait_b_timeout", 0, 1);
            break;
         end
      end
      #2 rst = 1'b1;
      #1 check_all_zero("rst_mid");
      @(negedge clk);
      rst = 1'b0;
      b_valid = 1'b1;
      dc = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done) dc++;
      end
      check("no_done_after_rst", dc, 0);
      check("idle_after_rst", busy, 0);
   endtask

   initial begin
      rst = 1'b1;
      start_a = 1'b0; start_b = 1'b0;
      addr = '0; len = '0; data_valid = 1'b0; data = '0;
      aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = '0;
      use_b = 1'b0;
      #12;
      check_all_zero("reset_a");
      use_b = 1'b1;
      check_all_zero("reset_b");
      @(negedge clk);
      rst = 1'b0;

      run_burst(1'b0, 4'h3, 4'd3, 16'h0000, 0);
      run_burst(1'b0, 4'h5, 4'd1, 16'h0000, 2);
      run_burst(1'b0, 4'h2, 4'd4, 16'h0002, 0);
      run_burst(1'b1, 4'h2, 4'd4, 16'h0002, 0);
      run_burst(1'b0, 4'hF, 4'd2, 16'h0000, 0);
      run_burst(1'b0, 4'h9, 4'd0, 16'h0000, 0);
      run_burst(1'b1, 4'h9, 4'd0, 16'h0000, 1);
      reset_mid_wait_b();
      run_burst(1'b0, 4'h1, 4'd2, 16'h0000, 0);

      for (int k = 0; k < 24; k++) begin
         run_burst(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   (($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0000), 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
